// File: rtl/pc_redirect_ctrl.sv
// Fetch-stage PC sequencer: merges branch/trap redirects, load-use stalls and imem readiness.
// Optional saturating performance counters are built when PC_REDIRECT_PERF_EN is defined.
module pc_redirect_ctrl #(
    parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100,
    parameter int          CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             br_taken,
    input  logic [31:0]      br_target,
    input  logic             trap_req,
    input  logic             hz_stall,
    input  logic             imem_ready,
    output logic             pc_sel,
    output logic             pc_stall,
    output logic [31:0]      branch_target,
    output logic             flush_if,
    output logic             flush_id,
    output logic             redirect_pending,
`ifdef PC_REDIRECT_PERF_EN
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] redirect_cnt,
`endif
    output logic             state_dbg
);

    // Interface contract: the PC register samples pc_sel/pc_stall/branch_target at the
    // next rising edge; pc_sel is only ever asserted in a cycle where pc_stall is low.

    typedef enum logic {
        RUN  = 1'b0,
        PEND = 1'b1
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pend_target, pend_target_nxt;

    logic        req;
    logic [31:0] req_target;

    assign req        = trap_req | br_taken;
    assign req_target = trap_req ? TRAP_VECTOR : br_target;
    assign state_dbg  = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= RUN;
            pend_target <= 32'h0;
        end else begin
            state       <= state_nxt;
            pend_target <= pend_target_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        pend_target_nxt = pend_target;
        case (state)
            RUN: begin
                if (req && !imem_ready) begin
                    state_nxt       = PEND;
                    pend_target_nxt = req_target;
                end
            end
            PEND: begin
                if (imem_ready) begin
                    state_nxt = RUN;
                end else if (trap_req) begin
                    pend_target_nxt = TRAP_VECTOR;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    // Wrong-path work was already flushed on entry to PEND, so only a trap re-flushes there.
    always_comb begin
        pc_sel           = 1'b0;
        pc_stall         = 1'b0;
        branch_target    = pend_target;
        flush_if         = 1'b0;
        flush_id         = 1'b0;
        redirect_pending = 1'b0;
        if (!rst) begin
            pc_stall      = 1'b1;
            branch_target = 32'h0;
        end else begin
            case (state)
                RUN: begin
                    if (req) begin
                        flush_if      = 1'b1;
                        flush_id      = 1'b1;
                        branch_target = req_target;
                        pc_sel        = imem_ready;
                        pc_stall      = ~imem_ready;
                    end else begin
                        pc_stall = hz_stall | ~imem_ready;
                    end
                end
                PEND: begin
                    redirect_pending = 1'b1;
                    flush_if         = trap_req;
                    flush_id         = trap_req;
                    branch_target    = trap_req ? TRAP_VECTOR : pend_target;
                    pc_sel           = imem_ready;
                    pc_stall         = ~imem_ready;
                end
                default: pc_stall = 1'b1;
            endcase
        end
    end

`ifdef PC_REDIRECT_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles <= '0;
            redirect_cnt <= '0;
        end else begin
            if (pc_stall && (stall_cycles != {CNT_W{1'b1}})) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
            if (pc_sel && (redirect_cnt != {CNT_W{1'b1}})) begin
                redirect_cnt <= redirect_cnt + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed scoreboard bench for pc_redirect_ctrl; counter checks are built when
// PC_REDIRECT_PERF_EN is defined.
module tb_pc_redirect_ctrl;

    localparam int CNT_W = 4;

    logic        clk;
    logic        rst;
    logic        br_taken;
    logic [31:0] br_target;
    logic        trap_req;
    logic        hz_stall;
    logic        imem_ready;
    logic        pc_sel;
    logic        pc_stall;
    logic [31:0] branch_target;
    logic        flush_if;
    logic        flush_id;
    logic        redirect_pending;
    logic        state_dbg;
`ifdef PC_REDIRECT_PERF_EN
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] redirect_cnt;
`endif

    pc_redirect_ctrl #(
        .TRAP_VECTOR(32'h0000_0100),
        .CNT_W      (CNT_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .br_taken        (br_taken),
        .br_target       (br_target),
        .trap_req        (trap_req),
        .hz_stall        (hz_stall),
        .imem_ready      (imem_ready),
        .pc_sel          (pc_sel),
        .pc_stall        (pc_stall),
        .branch_target   (branch_target),
        .flush_if        (flush_if),
        .flush_id        (flush_id),
        .redirect_pending(redirect_pending),
`ifdef PC_REDIRECT_PERF_EN
        .stall_cycles    (stall_cycles),
        .redirect_cnt    (redirect_cnt),
`endif
        .state_dbg       (state_dbg)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Packed view {redirect_pending, flush_if, flush_id, pc_stall, pc_sel, branch_target}
    logic [36:0] exp_q[$];
    string       tag_q[$];

    function automatic logic [36:0] e(input logic pend, input logic fi, input logic fd,
                                      input logic st, input logic sel, input logic [31:0] tgt);
        return {pend, fi, fd, st, sel, tgt};
    endfunction

    function automatic logic [36:0] observed();
        return {redirect_pending, flush_if, flush_id, pc_stall, pc_sel, branch_target};
    endfunction

    task automatic check(input string tag, input logic [36:0] obs, input logic [36:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Driver: called at posedge+1; drives one cycle, scoreboard compares at the negedge.
    task automatic step(input string tag, input logic br, input logic [31:0] tgt,
                        input logic trap, input logic hz, input logic rdy,
                        input logic [36:0] exp);
        logic [36:0] x;
        logic [36:0] o;
        string       t;
        br_taken   = br;
        br_target  = tgt;
        trap_req   = trap;
        hz_stall   = hz;
        imem_ready = rdy;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(negedge clk);
        x = exp_q.pop_front();
        t = tag_q.pop_front();
        o = observed();
        // The target is only meaningful when the PC register loads it.
        if (!x[32]) begin
            x[31:0] = 32'h0;
            o[31:0] = 32'h0;
        end
        check(t, o, x);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst        = 1'b0;
        br_taken   = 1'b1;
        br_target  = 32'h40;
        trap_req   = 1'b1;
        hz_stall   = 1'b0;
        imem_ready = 1'b1;
        #2;
        check("reset_forced", observed(), e(0, 0, 0, 1, 0, 32'h0));
        @(posedge clk);
        #1;
        check("reset_forced_edge", observed(), e(0, 0, 0, 1, 0, 32'h0));
`ifdef PC_REDIRECT_PERF_EN
        check("reset_stall_cnt", 37'(stall_cycles), 37'd0);
        check("reset_redir_cnt", 37'(redirect_cnt), 37'd0);
`endif
        br_taken = 1'b0;
        trap_req = 1'b0;
        rst      = 1'b1;

        // Redirect while memory busy for 3 cycles, then replay
        step("s2_capture", 1, 32'h80, 0, 0, 0, e(0, 1, 1, 1, 0, 32'h0));
        step("s2_pend1",   0, 32'h0,  0, 0, 0, e(1, 0, 0, 1, 0, 32'h0));
        step("s2_pend2",   0, 32'h0,  0, 0, 0, e(1, 0, 0, 1, 0, 32'h0));
        step("s2_replay",  0, 32'h0,  0, 0, 1, e(1, 0, 0, 0, 1, 32'h80));
        step("s2_run",     0, 32'h0,  0, 0, 1, e(0, 0, 0, 0, 0, 32'h0));
`ifdef PC_REDIRECT_PERF_EN
        check("s2_stall_cnt", 37'(stall_cycles), 37'd3);
        check("s2_redir_cnt", 37'(redirect_cnt), 37'd1);
`endif

        // Zero-latency redirect
        step("s1_redirect", 1, 32'h40, 0, 0, 1, e(0, 1, 1, 0, 1, 32'h40));
        step("s1_after",    0, 32'h0,  0, 0, 1, e(0, 0, 0, 0, 0, 32'h0));

        // Trap priority and trap overwrite while pending
        step("s3_trap_prio", 1, 32'h40, 1, 0, 1, e(0, 1, 1, 0, 1, 32'h100));
        step("s3_capture",   1, 32'h80, 0, 0, 0, e(0, 1, 1, 1, 0, 32'h0));
        step("s3_trap_pend", 0, 32'h0,  1, 0, 0, e(1, 1, 1, 1, 0, 32'h0));
        step("s3_br_ignored",1, 32'h40, 0, 1, 0, e(1, 0, 0, 1, 0, 32'h0));
        step("s3_apply",     0, 32'h0,  0, 0, 1, e(1, 0, 0, 0, 1, 32'h100));
        step("s3_run",       0, 32'h0,  0, 0, 1, e(0, 0, 0, 0, 0, 32'h0));
        step("s3_capture2",  1, 32'h80, 0, 0, 0, e(0, 1, 1, 1, 0, 32'h0));
        step("s3_trap_now",  0, 32'h0,  1, 0, 1, e(1, 1, 1, 0, 1, 32'h100));

        // Load-use hazard, and redirect overriding it
        step("s4_hz1",      0, 32'h0,   0, 1, 1, e(0, 0, 0, 1, 0, 32'h0));
        step("s4_hz2",      0, 32'h0,   0, 1, 1, e(0, 0, 0, 1, 0, 32'h0));
        step("s4_hz_br",    1, 32'h200, 0, 1, 1, e(0, 1, 1, 0, 1, 32'h200));
        step("s4_capture",  1, 32'h300, 0, 0, 0, e(0, 1, 1, 1, 0, 32'h0));
        step("s4_hz_pend",  0, 32'h0,   0, 1, 1, e(1, 0, 0, 0, 1, 32'h300));
        step("s4_idle_busy",0, 32'h0,   0, 0, 0, e(0, 0, 0, 1, 0, 32'h0));

        // Long stall run; counter saturates at all-ones
        for (int i = 0; i < 20; i++) begin
            step("sat_hz", 0, 32'h0, 0, 1, 1, e(0, 0, 0, 1, 0, 32'h0));
        end
`ifdef PC_REDIRECT_PERF_EN
        check("sat_stall_cnt", 37'(stall_cycles), 37'd15);
`endif

        // Async reset in the middle of PEND drops the captured redirect
        step("s5_capture", 1, 32'h80, 0, 0, 0, e(0, 1, 1, 1, 0, 32'h0));
        br_taken   = 1'b0;
        imem_ready = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        check("s5_reset_forced", observed(), e(0, 0, 0, 1, 0, 32'h0));
`ifdef PC_REDIRECT_PERF_EN
        check("s5_reset_stall_cnt", 37'(stall_cycles), 37'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b1;
        step("s5_no_replay1", 0, 32'h0, 0, 0, 1, e(0, 0, 0, 0, 0, 32'h0));
        step("s5_no_replay2", 0, 32'h0, 0, 0, 1, e(0, 0, 0, 0, 0, 32'h0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
